// File: rtl/mcu_io_ctrl_if.sv
// Execute-stage store/read bus between the core and the MCU I/O block.
interface mcu_io_ctrl_if;
    logic       wr_en;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_hit;

    modport master (output wr_en, addr, wr_data, input rd_data, rd_hit);
    modport slave  (input wr_en, addr, wr_data, output rd_data, rd_hit);
endinterface

// File: rtl/mcu_io_ctrl.sv
// Memory-mapped board I/O: 8-byte register window with output latches, synchronized
// (optionally debounced via MCU_IO_DEBOUNCE_EN) inputs, sticky W1C edge flags and masked irq.
module mcu_io_ctrl #(
    parameter logic [7:0]  BASE_ADDR       = 8'hF0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    mcu_io_ctrl_if.slave  bus,
    input  logic [8:0]    fpga_in,
    output logic [9:0]    fpga_out,
    output logic          irq
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
        $error("mcu_io_ctrl: DEBOUNCE_CYCLES out of range 2..255");
    end

    logic [7:0] out_lo_q, out_lo_d;
    logic [1:0] out_hi_q, out_hi_d;
    logic [8:0] edge_q,   edge_d;
    logic [8:0] mask_q,   mask_d;
    logic [8:0] sync1_q,  sync2_q;
    logic [8:0] filt;      // current filtered input
    logic [8:0] filt_nxt;  // value filt takes at the coming edge
    logic [8:0] edge_set;
    logic       hit;
    logic [2:0] off;

    assign hit = (bus.addr[7:3] == BASE_ADDR[7:3]);
    assign off = bus.addr[2:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= fpga_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef MCU_IO_DEBOUNCE_EN
    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [8:0]      filt_q, filt_d;
    logic [8:0][7:0] cnt_q,  cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int unsigned i = 0; i < 9; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt     = filt_q;
    assign filt_nxt = filt_d;
`else
    // Filtered value is the synchronizer output itself; its next value is the first stage.
    assign filt     = sync2_q;
    assign filt_nxt = sync1_q;
`endif

    // Flag sets on the same edge the filtered value rises, so it lines up with IN_*.
    assign edge_set = filt_nxt & ~filt;

    always_comb begin
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        edge_d   = edge_q;
        mask_d   = mask_q;
        if (bus.wr_en && hit) begin
            case (off)
                3'd0: out_lo_d       = bus.wr_data;
                3'd1: out_hi_d       = bus.wr_data[1:0];
                3'd4: edge_d[7:0]    = edge_q[7:0] & ~bus.wr_data;
                3'd5: edge_d[8]      = edge_q[8] & ~bus.wr_data[0];
                3'd6: mask_d[7:0]    = bus.wr_data;
                3'd7: mask_d[8]      = bus.wr_data[0];
                default: ;
            endcase
        end
        edge_d = edge_d | edge_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_lo_q <= '0;
            out_hi_q <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
        end else begin
            out_lo_q <= out_lo_d;
            out_hi_q <= out_hi_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (hit) begin
            case (off)
                3'd0: bus.rd_data = out_lo_q;
                3'd1: bus.rd_data = {6'b0, out_hi_q};
                3'd2: bus.rd_data = filt[7:0];
                3'd3: bus.rd_data = {7'b0, filt[8]};
                3'd4: bus.rd_data = edge_q[7:0];
                3'd5: bus.rd_data = {7'b0, edge_q[8]};
                3'd6: bus.rd_data = mask_q[7:0];
                default: bus.rd_data = {7'b0, mask_q[8]};
            endcase
        end
    end

    assign bus.rd_hit = hit;
    assign fpga_out   = {out_hi_q, out_lo_q};
    assign irq        = |(edge_q & mask_q);

endmodule

// File: doc/mcu_io_ctrl.md
MCU_IO_CTRL -- requirements
Module: mcu_io_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 8'hF0: base of the 8-byte I/O window, aligned to 8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, range 2..255: stable-cycle count required to accept an input change.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port wr_en, input, 1 bit: store strobe from the execute stage (MW).
REQ-006 Port addr, input, 8 bits: byte address (execute-stage bus A).
REQ-007 Port wr_data, input, 8 bits: store data (execute-stage bus B).
REQ-008 Port rd_data, output, 8 bits: read data for the addressed register.
REQ-009 Port rd_hit, output, 1 bit: addr lies within BASE_ADDR..BASE_ADDR+7.
REQ-010 Port fpga_in, input, 9 bits: asynchronous board inputs.
REQ-011 Port fpga_out, output, 10 bits: registered board outputs.
REQ-012 Port irq, output, 1 bit: level interrupt request.

Function
REQ-013 The register map (offset from BASE_ADDR) SHALL be:
- 0: OUT_LO, R/W, drives fpga_out[7:0].
- 1: OUT_HI, R/W bits[1:0] only, drives fpga_out[9:8]; bits[7:2] read 0.
- 2: IN_LO, RO, filtered fpga_in[7:0].
- 3: IN_HI, RO, bit0 = filtered fpga_in[8].
- 4: EDGE_LO, W1C, sticky rising-edge flags for inputs 7:0.
- 5: EDGE_HI, W1C, bit0 = flag for input 8.
- 6: MASK_LO, R/W.
- 7: MASK_HI, R/W bit0 only.
REQ-014 rd_hit and rd_data SHALL be combinational from addr with zero latency; rd_data SHALL be 0 when rd_hit=0.
REQ-015 A write SHALL take effect at the rising clk edge on which wr_en=1 and rd_hit=1; writes with rd_hit=0 and writes to RO offsets SHALL be ignored.
REQ-016 fpga_out SHALL equal the OUT registers directly, so a write is visible on the pins one cycle after the strobe.
REQ-017 Every fpga_in bit SHALL pass through a two-flop synchronizer before any other use.
REQ-018 An EDGE flag SHALL set on the cycle the filtered input goes 0->1, and SHALL stay set until cleared by writing 1 to that bit.
REQ-019 If a set and a W1C clear occur on the same edge, the set SHALL win.
REQ-020 irq SHALL equal the OR over bits of (EDGE & MASK); it is registered-free, derived combinationally from flops.
REQ-021 The filtered input SHALL be the debounced value when MCU_IO_DEBOUNCE_EN is defined, and the synchronized value otherwise.

Reset
REQ-022 Asserting reset (low) SHALL immediately clear all of the following to 0, independent of clk:
- OUT_LO, OUT_HI and fpga_out;
- EDGE and MASK;
- synchronizer flops, filtered values and debounce counters.
REQ-023 The first rising-edge detection after reset SHALL require a 0->1 transition of the filtered value; an input held high through reset SHALL set its flag once filtering reports 1.
REQ-024 A reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-025 With MCU_IO_DEBOUNCE_EN defined, each input SHALL have an 8-bit counter:
- The counter increments while the synchronized value differs from the filtered value.
- The counter clears when the two values match.
- The filtered value takes the synchronized value when the counter reaches DEBOUNCE_CYCLES-1, and the counter clears at that point.
REQ-026 Without MCU_IO_DEBOUNCE_EN, no counters SHALL be synthesized, and the filtered value SHALL equal the synchronizer output, giving a 2-cycle input latency.

Verification
REQ-027 Reset release, then write 0xA5 at addr 0xF0 -> fpga_out[7:0]=0xA5 one cycle later; read 0xF0 returns 0xA5.
REQ-028 Write 0xFF at addr 0xF1 -> fpga_out[9:8]=2'b11; read 0xF1 returns 0x03; write at addr 0xE0 leaves all registers unchanged and rd_hit=0.
REQ-029 Debounce on, DEBOUNCE_CYCLES=16, fpga_in[3] steps 0->1 -> IN_LO bit3 and EDGE_LO bit3 set exactly 2+16 cycles after the step; a 10-cycle glitch produces no change.
REQ-030 Debounce off, fpga_in[8] rises, MASK_HI=1 -> EDGE_HI bit0 set and irq=1 after 2 cycles; write 0x01 to 0xF5 -> irq=0 next cycle.
REQ-031 A W1C write of EDGE bit0 on the same edge as a new rising edge on input 0 -> the flag remains 1.
REQ-032 Reset asserted asynchronously with OUT_LO=0x3C and a debounce in progress -> fpga_out=0 before the next clk edge, and no edge flag set after release.
